// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational ROM with an
// optional wait-state count and hands {pc, instr} to decode over valid/ready.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic [31:0] pc_r;
    logic [3:0]  wait_cnt_r;
    logic        out_valid_r;
    logic [31:0] out_pc_r;
    logic [31:0] out_instr_r;

    logic [31:0] pc_nxt_s;
    logic [3:0]  wait_cnt_nxt_s;
    logic        out_valid_nxt_s;
    logic [31:0] out_pc_nxt_s;
    logic [31:0] out_instr_nxt_s;
    logic        slot_free_s;

    assign slot_free_s = ~out_valid_r | out_ready;

    // Next-state selection: redirect beats the wait countdown, which beats capture/stall.
    always_comb begin
        pc_nxt_s        = pc_r;
        wait_cnt_nxt_s  = wait_cnt_r;
        out_valid_nxt_s = out_valid_r;
        out_pc_nxt_s    = out_pc_r;
        out_instr_nxt_s = out_instr_r;
        if (redirect_valid) begin
            // A held word is dropped even if decode accepts it this cycle.
            pc_nxt_s        = {redirect_pc[31:2], 2'b00};
            out_valid_nxt_s = 1'b0;
            wait_cnt_nxt_s  = WAIT_INIT;
        end else if (wait_cnt_r != 4'd0) begin
            // Countdown keeps running during a downstream stall (prefetch overlap).
            wait_cnt_nxt_s  = wait_cnt_r - 4'd1;
            if (out_valid_r && out_ready) begin
                out_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s = out_valid_r;
            end
        end else if (slot_free_s) begin
            out_instr_nxt_s = rom_rdata;
            out_pc_nxt_s    = pc_r;
            out_valid_nxt_s = 1'b1;
            pc_nxt_s        = pc_r + 32'd4;
            wait_cnt_nxt_s  = WAIT_INIT;
        end else begin
            pc_nxt_s        = pc_r;
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= RESET_PC;
            wait_cnt_r  <= WAIT_INIT;
            out_valid_r <= 1'b0;
            out_pc_r    <= 32'h0000_0000;
            out_instr_r <= 32'h0000_0000;
        end else begin
            pc_r        <= pc_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_pc_r    <= out_pc_nxt_s;
            out_instr_r <= out_instr_nxt_s;
        end
    end

    assign rom_addr  = pc_r;
    assign out_valid = out_valid_r;
    assign out_pc    = out_pc_r;
    assign out_instr = out_instr_r;

endmodule
